// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address stack controller: command encodings,
// controller states and the spill-slot address helper.
package call_stack_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2
    } state_t;

    // Byte address of spill slot 'slot' given the spill-region base.
    function automatic logic [31:0] slot_to_addr(input logic [31:0] base, input logic [31:0] slot);
        return base + (slot << 2);
    endfunction

endpackage

// File: rtl/stack_ring_buf.sv
// On-chip LIFO storage: circular register array with a top pointer (push/pop end)
// and a bottom pointer (spill/fill end). The data array is intentionally not reset.
module stack_ring_buf #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_en,
    input  logic [DW-1:0] push_data,
    input  logic          pop_en,
    input  logic          spill_en,
    input  logic          fill_en,
    input  logic [DW-1:0] fill_data,
    output logic [DW-1:0] top_data,
    output logic [DW-1:0] bot_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] top;
    logic [PW-1:0] bot;
    logic [PW-1:0] top_m1;
    logic [PW-1:0] bot_m1;

    assign top_m1   = top - PW'(1);
    assign bot_m1   = bot - PW'(1);
    assign top_data = mem[top_m1];
    assign bot_data = mem[bot];

    // Pointer updates; push/pop and spill/fill are mutually exclusive by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top <= '0;
            bot <= '0;
        end else begin
            if (push_en) begin
                top <= top + PW'(1);
            end else if (pop_en) begin
                top <= top_m1;
            end
            if (spill_en) begin
                bot <= bot + PW'(1);
            end else if (fill_en) begin
                bot <= bot_m1;
            end
        end
    end

    // Entry writes: new pushes at the top, refilled entries just below the bottom.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[top] <= push_data;
        end else if (fill_en) begin
            mem[bot_m1] <= fill_data;
        end
    end

endmodule

// File: rtl/call_stack_ctrl.sv
// Return-address stack controller: serves push/pop commands from a small on-chip
// ring, spilling the oldest entry to data memory when full and refilling on demand.
// Optional build macro CALL_STACK_EAGER_FILL_EN: refill proactively while idle
// whenever fewer than LOW_MARK entries remain on chip.
module call_stack_ctrl
    import call_stack_pkg::*;
#(
    parameter int unsigned   DW         = 32,
    parameter int unsigned   DEPTH      = 8,
    parameter int unsigned   MEM_DEPTH  = 64,
    parameter int unsigned   AW         = 32,
    parameter logic [AW-1:0] SPILL_BASE = AW'(32'h0000_0F00),
    parameter int unsigned   LOW_MARK   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    input  logic          cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          cmd_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          ovrflw,
    output logic          undrflw,
    output logic [7:0]    depth
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(MEM_DEPTH + 1);

`ifdef CALL_STACK_EAGER_FILL_EN
    localparam bit EAGER = 1'b1;
`else
    localparam bit EAGER = 1'b0;
`endif

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [SW-1:0] sp_cnt;
    logic [SW-1:0] sp_n;
    logic [DW-1:0] top_data;
    logic [DW-1:0] bot_data;

    logic is_push, ring_full, ring_empty, mem_full, mem_empty;
    logic need_spill, need_fill, eager_fill;
    logic accept, push_wr, push_drop, pop_rd, pop_empty;
    logic spill_done, fill_done;

    // Command classification and handshake.
    assign is_push    = (cmd_op == OP_PUSH);
    assign ring_full  = (cnt == CW'(DEPTH));
    assign ring_empty = (cnt == '0);
    assign mem_full   = (sp_cnt == SW'(MEM_DEPTH));
    assign mem_empty  = (sp_cnt == '0);
    assign need_spill = cmd_valid && is_push && ring_full && !mem_full;
    assign need_fill  = cmd_valid && !is_push && ring_empty && !mem_empty;
    assign eager_fill = EAGER && !cmd_valid && (cnt < CW'(LOW_MARK)) && !mem_empty;
    assign cmd_ready  = (state == IDLE) && !need_spill && !need_fill;
    assign accept     = cmd_valid && cmd_ready;
    assign push_wr    = accept && is_push && !ring_full;
    assign push_drop  = accept && is_push && ring_full;
    assign pop_rd     = accept && !is_push && !ring_empty;
    assign pop_empty  = accept && !is_push && ring_empty;
    assign spill_done = (state == SPILL) && mem_ack;
    assign fill_done  = (state == FILL) && mem_ack;

    stack_ring_buf #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_en   (push_wr),
        .push_data (cmd_data),
        .pop_en    (pop_rd),
        .spill_en  (spill_done),
        .fill_en   (fill_done),
        .fill_data (mem_rdata),
        .top_data  (top_data),
        .bot_data  (bot_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (need_spill) begin
                    state_n = SPILL;
                end else if (need_fill || eager_fill) begin
                    state_n = FILL;
                end
            end
            SPILL:   if (mem_ack) state_n = IDLE;
            FILL:    if (mem_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Memory-port decode; stable through a transaction since counters and ring are frozen.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            SPILL: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = AW'(slot_to_addr(32'(SPILL_BASE), 32'(sp_cnt)));
                mem_wdata = bot_data;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = AW'(slot_to_addr(32'(SPILL_BASE), 32'(sp_cnt - SW'(1))));
            end
            default: ;
        endcase
    end

    // Occupancy bookkeeping; at most one event per cycle.
    always_comb begin
        cnt_n = cnt;
        sp_n  = sp_cnt;
        if (push_wr) begin
            cnt_n = cnt + CW'(1);
        end else if (pop_rd) begin
            cnt_n = cnt - CW'(1);
        end else if (spill_done) begin
            cnt_n = cnt - CW'(1);
            sp_n  = sp_cnt + SW'(1);
        end else if (fill_done) begin
            cnt_n = cnt + CW'(1);
            sp_n  = sp_cnt - SW'(1);
        end
    end

    // Counters, depth, pop response and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            sp_cnt    <= '0;
            depth     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            ovrflw    <= 1'b0;
            undrflw   <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            sp_cnt    <= sp_n;
            depth     <= 8'(cnt_n) + 8'(sp_n);
            rsp_valid <= pop_rd || pop_empty;
            rsp_data  <= pop_rd ? top_data : '0;
            if (push_drop) ovrflw  <= 1'b1;
            if (pop_empty) undrflw <= 1'b1;
        end
    end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: reference LIFO model, response scoreboard
// and a behavioural spill-memory responder with variable ack latency.
module tb_call_stack_ctrl;

    localparam int unsigned TOTAL = 72;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_op;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        ovrflw;
    logic        undrflw;
    logic [7:0]  depth;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model_stk[$];
    logic [31:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    logic        exp_udf = 1'b0;

    logic [31:0] smem [64];
    bit          mem_auto = 1'b1;
    int          n_wr = 0;
    int          n_rd = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] last_rd_addr = '0;

    call_stack_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ovrflw    (ovrflw),
        .undrflw   (undrflw),
        .depth     (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Spill-region memory: acks each request after 0..2 extra cycles.
    initial begin : mem_model
        int lat_cnt;
        int cur_lat;
        int unsigned idx;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        lat_cnt   = 0;
        cur_lat   = 1;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req && mem_auto) begin
                if (lat_cnt >= cur_lat) begin
                    idx = (mem_addr - 32'h0000_0F00) >> 2;
                    n_cmp++;
                    if (idx >= 64 || mem_addr[1:0] != 2'b00) begin
                        n_err++;
                        $display("FAIL mem_addr_range: got %h, required word in 0xF00..0xFFC", mem_addr);
                        idx = 0;
                    end
                    if (mem_we) begin
                        smem[idx]    = mem_wdata;
                        n_wr++;
                        last_wr_addr = mem_addr;
                        last_wr_data = mem_wdata;
                    end else begin
                        mem_rdata    = smem[idx];
                        n_rd++;
                        last_rd_addr = mem_addr;
                    end
                    mem_ack = 1'b1;
                    lat_cnt = 0;
                    cur_lat = $urandom_range(0, 2);
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Response scoreboard: every rsp_valid pulse must match the oldest expectation.
    initial begin : rsp_monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected: got rsp_data %h, required no response", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_data !== e) begin
                        n_err++;
                        $display("FAIL rsp_data: got %h, required %h", rsp_data, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one command from a +1 phase; returns with the bench at +1 after the accept edge.
    task automatic do_cmd(input logic op, input logic [31:0] data, output int stalls);
        bit acc;
        int budget;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        stalls    = 0;
        acc       = 1'b0;
        budget    = 0;
        while (!acc && budget < 300) begin
            #2;
            acc = cmd_ready;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
            budget++;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL cmd_accept: op %0d not accepted after %0d cycles, required acceptance", op, budget);
        end else if (op == 1'b0) begin
            if (model_stk.size() < TOTAL) model_stk.push_back(data);
            else exp_ovf = 1'b1;
        end else begin
            if (model_stk.size() > 0) begin
                exp_q.push_back(model_stk.pop_back());
            end else begin
                exp_q.push_back(32'h0);
                exp_udf = 1'b1;
            end
            n_cmp++;
            if (rsp_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rsp_latency: rsp_valid %b one cycle after pop accept, required 1", rsp_valid);
            end
        end
    endtask

    task automatic apply_reset();
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_data  = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_stk.delete();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (depth !== 8'd0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: depth %0d ready %b rsp_valid %b mem_req %b, required 0 1 0 0",
                     depth, cmd_ready, rsp_valid, mem_req);
        end
        n_cmp++;
        if (ovrflw !== 1'b0 || undrflw !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: ovrflw %b undrflw %b, required 0 0", ovrflw, undrflw);
        end
    endtask

    task automatic test_lifo();
        int s;
        do_cmd(1'b0, 32'h10, s);
        do_cmd(1'b0, 32'h20, s);
        do_cmd(1'b0, 32'h30, s);
        n_cmp++;
        if (depth !== 8'd3) begin
            n_err++;
            $display("FAIL lifo_depth3: got %0d, required 3", depth);
        end
        repeat (3) do_cmd(1'b1, 32'h0, s);
        @(posedge clk);
        #1;
        n_cmp++;
        if (depth !== 8'd0 || ovrflw !== 1'b0 || undrflw !== 1'b0) begin
            n_err++;
            $display("FAIL lifo_end: depth %0d ovrflw %b undrflw %b, required 0 0 0", depth, ovrflw, undrflw);
        end
    endtask

    task automatic test_spill();
        int s;
        n_wr = 0;
        for (int i = 1; i <= 8; i++) do_cmd(1'b0, 32'(i), s);
        n_cmp++;
        if (n_wr != 0) begin
            n_err++;
            $display("FAIL spill_early: %0d memory writes with ring not full, required 0", n_wr);
        end
        do_cmd(1'b0, 32'd9, s);
        n_cmp++;
        if (s == 0) begin
            n_err++;
            $display("FAIL spill_stall: 9th push stalled %0d cycles, required > 0", s);
        end
        n_cmp++;
        if (n_wr != 1 || last_wr_addr !== 32'h0F00 || last_wr_data !== 32'd1) begin
            n_err++;
            $display("FAIL spill_write: %0d writes, addr %h data %h, required 1 write of 1 to 0xF00",
                     n_wr, last_wr_addr, last_wr_data);
        end
        n_cmp++;
        if (depth !== 8'd9) begin
            n_err++;
            $display("FAIL spill_depth: got %0d, required 9", depth);
        end
    endtask

    task automatic test_fill();
        int s;
        n_rd = 0;
        repeat (8) do_cmd(1'b1, 32'h0, s);
        n_cmp++;
        if (n_rd != 0 || depth !== 8'd1) begin
            n_err++;
            $display("FAIL fill_early: %0d reads depth %0d, required 0 reads depth 1", n_rd, depth);
        end
        do_cmd(1'b1, 32'h0, s);
        n_cmp++;
        if (n_rd != 1 || last_rd_addr !== 32'h0F00) begin
            n_err++;
            $display("FAIL fill_read: %0d reads last addr %h, required 1 read of 0xF00", n_rd, last_rd_addr);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (depth !== 8'd0) begin
            n_err++;
            $display("FAIL fill_depth: got %0d, required 0", depth);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        do_cmd(1'b0, 32'hA1, s);
        do_cmd(1'b1, 32'h0,  s);
        do_cmd(1'b0, 32'hB2, s);
        do_cmd(1'b0, 32'hC3, s);
        do_cmd(1'b1, 32'h0,  s);
        do_cmd(1'b1, 32'h0,  s);
        @(posedge clk);
        #1;
        n_cmp++;
        if (depth !== 8'(model_stk.size())) begin
            n_err++;
            $display("FAIL b2b_depth: got %0d, required %0d", depth, model_stk.size());
        end
    endtask

    task automatic test_overflow();
        int s;
        n_wr = 0;
        n_rd = 0;
        for (int i = 0; i < int'(TOTAL); i++) do_cmd(1'b0, 32'(100 + i), s);
        n_cmp++;
        if (depth !== 8'(TOTAL) || n_wr != 64 || last_wr_addr !== 32'h0FFC) begin
            n_err++;
            $display("FAIL ovf_fill: depth %0d writes %0d last addr %h, required 72 64 0xFFC",
                     depth, n_wr, last_wr_addr);
        end
        do_cmd(1'b0, 32'hDEAD, s);
        n_cmp++;
        if (s != 0 || ovrflw !== exp_ovf || depth !== 8'(model_stk.size())) begin
            n_err++;
            $display("FAIL ovf_push: stalls %0d ovrflw %b depth %0d, required 0 %b %0d",
                     s, ovrflw, depth, exp_ovf, model_stk.size());
        end
        repeat (9) do_cmd(1'b1, 32'h0, s);
        @(posedge clk);
        #1;
        n_cmp++;
        if (n_rd != 1 || last_rd_addr !== 32'h0FFC || depth !== 8'(model_stk.size())) begin
            n_err++;
            $display("FAIL ovf_drain: reads %0d addr %h depth %0d, required 1 0xFFC %0d",
                     n_rd, last_rd_addr, depth, model_stk.size());
        end
    endtask

    task automatic test_underflow();
        int s;
        apply_reset();
        do_cmd(1'b1, 32'h0, s);
        @(posedge clk);
        #1;
        n_cmp++;
        if (undrflw !== exp_udf || depth !== 8'd0 || ovrflw !== 1'b0) begin
            n_err++;
            $display("FAIL udf_flag: undrflw %b depth %0d ovrflw %b, required %b 0 0",
                     undrflw, depth, ovrflw, exp_udf);
        end
        do_cmd(1'b0, 32'h5, s);
        do_cmd(1'b1, 32'h0, s);
        @(posedge clk);
        #1;
        n_cmp++;
        if (undrflw !== 1'b1 || depth !== 8'd0) begin
            n_err++;
            $display("FAIL udf_sticky: undrflw %b depth %0d, required 1 0", undrflw, depth);
        end
    endtask

    task automatic test_reset_mid_spill();
        int s;
        int w;
        mem_auto = 1'b0;
        for (int i = 0; i < 8; i++) do_cmd(1'b0, 32'(200 + i), s);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_data  = 32'h0BAD;
        w = 0;
        while (mem_req !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0F00 || mem_wdata !== model_stk[0]) begin
            n_err++;
            $display("FAIL rst_spill_req: req %b we %b addr %h wdata %h, required 1 1 0xF00 %h",
                     mem_req, mem_we, mem_addr, mem_wdata, model_stk[0]);
        end
        #2;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async_req: mem_req %b during reset, required 0", mem_req);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_stk.delete();
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        mem_auto = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (depth !== 8'd0 || cmd_ready !== 1'b1 || ovrflw !== 1'b0 || undrflw !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_release: depth %0d ready %b ovrflw %b undrflw %b req %b, required 0 1 0 0 0",
                     depth, cmd_ready, ovrflw, undrflw, mem_req);
        end
    endtask

    initial begin : main
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_data  = '0;
        test_reset();
        test_lifo();
        test_spill();
        test_fill();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_reset_mid_spill();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rsp_missing: %0d expected responses never arrived, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
- Return-address stack controller for the processor core: owns a small on-chip LIFO and transparently spills the oldest entries to data memory when it fills, and refills them when it drains.
- Serves push (call) and pop (return) commands from the control unit through a valid/ready handshake.
- Shares the data-memory port with the core through a single-outstanding req/ack interface.
- Flags unrecoverable overflow and underflow.

Parameters:
- DW, 32, stack entry width.
- DEPTH, 8, on-chip entries (power of 2).
- MEM_DEPTH, 64, max entries held in the spill region.
- AW, 32, memory byte-address width.
- SPILL_BASE, 32'h0000_0F00, byte address of spill slot 0. Slot i is at SPILL_BASE + 4*i.
- LOW_MARK, 2, eager-fill threshold (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_op  in  1  0 = push, 1 = pop.
- cmd_data  in  DW  push value.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- rsp_valid  out  1  one-cycle pulse carrying pop result.
- rsp_data  out  DW  popped value.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = spill write, 0 = fill read.
- mem_addr  out  AW  byte address.
- mem_wdata  out  DW  spill data.
- mem_rdata  in  DW  fill data, valid with mem_ack.
- mem_ack  in  1  request complete (one cycle).
- ovrflw  out  1  sticky: push lost.
- undrflw  out  1  sticky: pop of empty stack.
- depth  out  8  total entries (cnt + sp_cnt).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: cnt = 0, sp_cnt = 0, ring pointers = 0, state = IDLE. All outputs 0 (cmd_ready is 1 once IDLE). Reset mid-transaction drops mem_req immediately; the memory transaction is abandoned.
- State machine IDLE / SPILL / FILL:
  - IDLE:
    - cmd_ready = 1 unless (push && cnt == DEPTH && sp_cnt < MEM_DEPTH) or (pop && cnt == 0 && sp_cnt > 0). In those cases cmd_ready = 0 and the next state is SPILL or FILL respectively.
    - cmd_ready is combinational from cmd_valid, cmd_op, cnt, sp_cnt and state.
  - SPILL:
    - mem_req = 1, mem_we = 1, mem_addr = slot sp_cnt, mem_wdata = bottom entry.
    - On mem_ack: bot++, cnt--, sp_cnt++, go to IDLE. The pending push is accepted the following cycle.
  - FILL:
    - mem_req = 1, mem_we = 0, mem_addr = slot sp_cnt-1.
    - On mem_ack: write mem_rdata into slot bot-1, bot--, cnt++, sp_cnt--, go to IDLE.
  - mem_* outputs are held stable until mem_ack.
- Accepted push (space available): write at top, top++, cnt++ on the same edge.
- Accepted pop (cnt > 0): rsp_valid = 1 on the next cycle with the old top entry; top--, cnt--.
- Simultaneous events: only one command per cycle. A command held valid during SPILL/FILL stays pending. cmd_op and cmd_data must be stable while cmd_valid && !cmd_ready.
- Full boundary: push with cnt == DEPTH && sp_cnt == MEM_DEPTH is accepted and discarded; ovrflw is set. Stack contents are unchanged.
- Empty boundary: pop with cnt == 0 && sp_cnt == 0 is accepted; rsp_valid pulses with rsp_data = 0; undrflw is set.
- Flag clearing: ovrflw and undrflw clear only on reset.
- Wrap-around: ring pointers are log2(DEPTH) bits and wrap modulo DEPTH. sp_cnt never exceeds MEM_DEPTH.
- depth output: registered, equals cnt + sp_cnt.

Optional Feature:
- Macro: CALL_STACK_EAGER_FILL_EN.
- Defined: in IDLE with cmd_valid = 0, cnt < LOW_MARK and sp_cnt > 0, the controller enters FILL proactively. A command arriving mid-fill waits in FILL until mem_ack.
- Undefined: FILL is entered only on demand, when a pop hits an empty ring. LOW_MARK is ignored.

Decomposition:
- Package call_stack_pkg: OP_PUSH/OP_POP constants, state enum (IDLE, SPILL, FILL), slot-to-address function.
- Sub-module stack_ring_buf:
  - DEPTH x DW register array with top/bot pointers.
  - Write ports at top and at bot-1.
  - Read ports at top-1 and bot.
  - No reset on the data array.
- The controller holds the FSM, counters, flags and memory interface.

Test Plan:
1. Push 0x10, 0x20, 0x30; pop x3 -> rsp_data 0x30, 0x20, 0x10 (each 1 cycle after accept); depth returns to 0; no flags.
2. Push 9 values 1..9 with DEPTH = 8 -> 9th push stalls; a single mem write of value 1 goes to 0xF00; then the push is accepted; depth = 9.
3. Continue from 2: pop x9 -> values 9..2 returned without memory traffic; 9th pop triggers a read of 0xF00 and returns 1 after mem_ack.
4. Fill to DEPTH + MEM_DEPTH (72), push 0xDEAD -> accepted, ovrflw = 1, depth stays 72; next pop returns entry 72.
5. From reset, pop -> rsp_valid with rsp_data = 0, undrflw = 1; a later push 0x5 then pop returns 0x5 with undrflw still 1.
6. Assert rst_n low while mem_req is high in SPILL -> mem_req drops immediately; after release depth = 0, cmd_ready = 1, flags = 0.
